// File: rtl/tlu_trigger_number_transmitter_if.sv
// Handshake bundle between the TLU-side trigger-number transmitter and its environment.
interface tlu_trigger_number_transmitter_if #(
  parameter int DATA_BITS = 31
);
  logic                 enable;
  logic                 trigger_req;
  logic                 tlu_data_msb_first;
  logic                 trigger_number_load;
  logic [DATA_BITS-1:0] trigger_number_init;
  logic                 tlu_clock;
  logic                 tlu_busy;
  logic                 tlu_trigger;
  logic [DATA_BITS-1:0] trigger_number;
  logic                 tx_busy;
  logic [7:0]           missed_trigger_count;
  logic                 timeout_error;

  modport master (
    output enable, trigger_req, tlu_data_msb_first, trigger_number_load,
           trigger_number_init, tlu_clock, tlu_busy,
    input  tlu_trigger, trigger_number, tx_busy, missed_trigger_count, timeout_error
  );

  modport slave (
    input  enable, trigger_req, tlu_data_msb_first, trigger_number_load,
           trigger_number_init, tlu_clock, tlu_busy,
    output tlu_trigger, trigger_number, tx_busy, missed_trigger_count, timeout_error
  );
endinterface

// File: rtl/tlu_trigger_number_transmitter.sv
// TLU emulator: raises the trigger, then shifts the trigger number out on TLU clock rises.
// Optional busy-wait timeout enabled by defining TLU_TX_TIMEOUT_EN.
module tlu_trigger_number_transmitter #(
  parameter int DATA_BITS      = 31,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic rst,
  tlu_trigger_number_transmitter_if.slave bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] TRIGGER = 2'd1;
  localparam logic [1:0] SHIFT   = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;
  localparam int CNT_W = $clog2(DATA_BITS + 1);

  logic [1:0]           state;
  logic [DATA_BITS-1:0] sr;
  logic [DATA_BITS-1:0] num_rev;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 clk_q;
  logic                 clk_rise;
  logic                 req_missed;
  logic                 timeout_hit;

  always_comb begin
    num_rev = '0;
    for (int i = 0; i < DATA_BITS; i++) num_rev[i] = bus.trigger_number[DATA_BITS-1-i];
  end

  assign clk_rise    = bus.tlu_clock & ~clk_q;
  assign req_missed  = bus.trigger_req & ((state != IDLE) | ~bus.enable | bus.trigger_number_load);
  assign bus.tx_busy = (state != IDLE);

`ifdef TLU_TX_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        tmo_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
      tmo_err <= 1'b0;
    end else begin
      tmo_cnt <= (state == TRIGGER) ? tmo_cnt + 16'd1 : '0;
      if (timeout_hit) tmo_err <= 1'b1;
      else if (state == IDLE && bus.trigger_number_load) tmo_err <= 1'b0;
    end
  end

  assign timeout_hit       = (state == TRIGGER) & ~bus.tlu_busy & (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign bus.timeout_error = tmo_err;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit       = 1'b0;
  assign bus.timeout_error = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                    <= IDLE;
      sr                       <= '0;
      bit_cnt                  <= '0;
      clk_q                    <= 1'b0;
      bus.tlu_trigger          <= 1'b0;
      bus.trigger_number       <= '0;
      bus.missed_trigger_count <= '0;
    end else begin
      clk_q <= bus.tlu_clock;
      if (req_missed && bus.missed_trigger_count != 8'hFF)
        bus.missed_trigger_count <= bus.missed_trigger_count + 8'd1;
      case (state)
        IDLE: begin
          bus.tlu_trigger <= 1'b0;
          if (bus.trigger_number_load) begin
            // load wins over a simultaneous request, which is then the only miss left
            bus.trigger_number       <= bus.trigger_number_init;
            bus.missed_trigger_count <= {7'd0, bus.trigger_req};
          end else if (bus.trigger_req && bus.enable) begin
            sr              <= bus.tlu_data_msb_first ? bus.trigger_number : num_rev;
            bit_cnt         <= '0;
            bus.tlu_trigger <= 1'b1;
            state           <= TRIGGER;
          end
        end
        TRIGGER: begin
          if (bus.tlu_busy) begin
            bus.tlu_trigger <= 1'b0;
            state           <= SHIFT;
          end else if (timeout_hit) begin
            bus.tlu_trigger    <= 1'b0;
            bus.trigger_number <= bus.trigger_number + 1'b1;
            state              <= IDLE;
          end else begin
            bus.tlu_trigger <= 1'b1;
          end
        end
        SHIFT: begin
          if (!bus.tlu_busy) begin
            bus.tlu_trigger <= 1'b0;
            state           <= DONE;
          end else if (clk_rise) begin
            if (bit_cnt < CNT_W'(DATA_BITS)) begin
              bus.tlu_trigger <= sr[DATA_BITS-1];
              sr              <= sr << 1;
              bit_cnt         <= bit_cnt + 1'b1;
            end else begin
              bus.tlu_trigger <= 1'b0;
            end
          end
        end
        DONE: begin
          bus.tlu_trigger    <= 1'b0;
          bus.trigger_number <= bus.trigger_number + 1'b1;
          state              <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tlu_trigger_number_transmitter.sv
// Directed + randomized bench for the trigger-number transmitter with a loopback receiver model.
module tb_tlu_trigger_number_transmitter;
  localparam int DB  = 31;
  localparam int TMO = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tlu_trigger_number_transmitter_if #(.DATA_BITS(DB)) bus ();

  tlu_trigger_number_transmitter #(.DATA_BITS(DB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int total = 0;
  int bad   = 0;
  logic [DB-1:0] model_num;
  int model_missed;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic add_missed(input int n);
    model_missed = (model_missed + n > 255) ? 255 : model_missed + n;
  endtask

  task automatic load(input logic [DB-1:0] v);
    bus.trigger_number_init = v;
    bus.trigger_number_load = 1'b1;
    step();
    bus.trigger_number_load = 1'b0;
    model_num    = v;
    model_missed = 0;
  endtask

  // Emulates the DUT side: takes the trigger, clocks npulses bits and rebuilds the word.
  task automatic transfer(input int npulses, input logic msb, input int req_during);
    logic [63:0]   rx, exp;
    logic [DB-1:0] n, recon;
    n  = model_num;
    rx = '0;
    bus.tlu_data_msb_first = msb;
    bus.trigger_req = 1'b1;
    step();
    bus.trigger_req = 1'b0;
    chk("trigger_high", 64'(bus.tlu_trigger), 64'd1);
    chk("tx_busy_high", 64'(bus.tx_busy), 64'd1);
    bus.tlu_busy = 1'b1;
    step();
    chk("first_zero_bit", 64'(bus.tlu_trigger), 64'd0);
    for (int i = 0; i < npulses; i++) begin
      bus.tlu_clock = 1'b1;
      if (i < req_during) bus.trigger_req = 1'b1;
      step();
      bus.trigger_req = 1'b0;
      rx[i] = bus.tlu_trigger;
      bus.tlu_clock = 1'b0;
      step();
    end
    add_missed(req_during);
    exp = '0;
    for (int i = 0; i < npulses && i < DB; i++) exp[i] = msb ? n[DB-1-i] : n[i];
    chk("stream", rx, exp);
    if (npulses >= DB) begin
      recon = '0;
      for (int i = 0; i < DB; i++) recon = recon | (DB'(rx[i]) << (msb ? DB-1-i : i));
      chk("loopback", 64'(recon), 64'(n));
    end
    bus.tlu_busy = 1'b0;
    step(2);
    model_num = n + 1'b1;
    chk("idle_after", 64'(bus.tx_busy), 64'd0);
    chk("number_inc", 64'(bus.trigger_number), 64'(model_num));
    chk("missed", 64'(bus.missed_trigger_count), 64'(model_missed));
  endtask

  initial begin
    logic [DB-1:0] old;
    int hi;
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.trigger_req = 1'b0;
    bus.tlu_data_msb_first = 1'b1;
    bus.trigger_number_load = 1'b0;
    bus.trigger_number_init = '0;
    bus.tlu_clock = 1'b0;
    bus.tlu_busy = 1'b0;
    model_num = '0;
    model_missed = 0;
    step(2);
    chk("rst_trigger", 64'(bus.tlu_trigger), 64'd0);
    chk("rst_tx_busy", 64'(bus.tx_busy), 64'd0);
    chk("rst_number", 64'(bus.trigger_number), 64'd0);
    chk("rst_missed", 64'(bus.missed_trigger_count), 64'd0);
    chk("rst_timeout", 64'(bus.timeout_error), 64'd0);
    rst = 1'b0;
    bus.enable = 1'b1;
    step();

    load(DB'(32'h12345678));
    transfer(32, 1'b1, 0);
    load(DB'(1));
    transfer(32, 1'b0, 0);
    load({DB{1'b1}});
    transfer(31, 1'b1, 0);

    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) load(DB'($urandom));
      transfer($urandom_range(DB + 3, DB - 4), 1'($urandom), 0);
    end

    transfer(32, 1'b1, 3);
    bus.enable = 1'b0;
    bus.trigger_req = 1'b1;
    step();
    bus.trigger_req = 1'b0;
    bus.enable = 1'b1;
    add_missed(1);
    chk("missed_four", 64'(bus.missed_trigger_count), 64'(model_missed));
    chk("disabled_no_start", 64'(bus.tx_busy), 64'd0);
    load(DB'(32'h00000100));
    chk("missed_clear", 64'(bus.missed_trigger_count), 64'd0);

    bus.enable = 1'b0;
    bus.trigger_req = 1'b1;
    step(260);
    bus.trigger_req = 1'b0;
    bus.enable = 1'b1;
    add_missed(260);
    chk("missed_sat", 64'(bus.missed_trigger_count), 64'(model_missed));

    bus.trigger_number_init = DB'(32'h55);
    bus.trigger_number_load = 1'b1;
    bus.trigger_req = 1'b1;
    step();
    bus.trigger_number_load = 1'b0;
    bus.trigger_req = 1'b0;
    model_num = DB'(32'h55);
    model_missed = 1;
    chk("load_req_idle", 64'(bus.tx_busy), 64'd0);
    chk("load_req_number", 64'(bus.trigger_number), 64'(model_num));
    chk("load_req_missed", 64'(bus.missed_trigger_count), 64'(model_missed));

    old = model_num;
    bus.trigger_req = 1'b1;
    step();
    bus.trigger_req = 1'b0;
    bus.tlu_busy = 1'b1;
    step();
    bus.trigger_number_init = DB'(3);
    bus.trigger_number_load = 1'b1;
    step();
    bus.trigger_number_load = 1'b0;
    bus.tlu_busy = 1'b0;
    step(2);
    model_num = old + 1'b1;
    chk("load_ignored", 64'(bus.trigger_number), 64'(model_num));

    bus.tlu_busy = 1'b1;
    bus.trigger_req = 1'b1;
    step();
    bus.trigger_req = 1'b0;
    chk("early_busy_trig", 64'(bus.tlu_trigger), 64'd1);
    step();
    chk("early_busy_one_cycle", 64'(bus.tlu_trigger), 64'd0);
    chk("early_busy_shift", 64'(bus.tx_busy), 64'd1);
    bus.tlu_busy = 1'b0;
    step(2);
    model_num = model_num + 1'b1;
    chk("early_busy_number", 64'(bus.trigger_number), 64'(model_num));

    bus.trigger_req = 1'b1;
    step();
    bus.trigger_req = 1'b0;
`ifdef TLU_TX_TIMEOUT_EN
    hi = 0;
    for (int c = 0; c < 100 && bus.tlu_trigger; c++) begin
      hi++;
      step();
    end
    model_num = model_num + 1'b1;
    chk("timeout_high_len", 64'(hi), 64'(TMO));
    chk("timeout_flag", 64'(bus.timeout_error), 64'd1);
    chk("timeout_idle", 64'(bus.tx_busy), 64'd0);
    chk("timeout_number", 64'(bus.trigger_number), 64'(model_num));
    load(DB'(7));
    chk("timeout_clear", 64'(bus.timeout_error), 64'd0);
`else
    hi = 0;
    step(40);
    chk("wait_forever_trig", 64'(bus.tlu_trigger), 64'd1);
    chk("no_timeout_flag", 64'(bus.timeout_error), 64'd0);
    bus.tlu_busy = 1'b1;
    step();
    bus.tlu_busy = 1'b0;
    step(2);
    model_num = model_num + 1'b1;
    chk("late_busy_number", 64'(bus.trigger_number), 64'(model_num));
`endif

    load(DB'(32'hABC));
    bus.tlu_data_msb_first = 1'b1;
    bus.trigger_req = 1'b1;
    step();
    bus.trigger_req = 1'b0;
    bus.tlu_busy = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      bus.tlu_clock = 1'b1;
      step();
      bus.tlu_clock = 1'b0;
      step();
    end
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_trigger", 64'(bus.tlu_trigger), 64'd0);
    chk("midrst_tx_busy", 64'(bus.tx_busy), 64'd0);
    chk("midrst_number", 64'(bus.trigger_number), 64'd0);
    bus.tlu_busy = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("post_rst_idle", 64'(bus.tx_busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
